// File: rtl/serial_pattern_detector_pkg.sv
// Shared types and default constants for the serial pattern detector.
package serial_pattern_detector_pkg;

  // Detector FSM states. IDLE is left only by the first accepted bit and
  // is re-entered only through reset.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Default pattern shape: four bits, MSB is the oldest bit received.
  localparam int         DEF_PATTERN_W = 4;
  localparam logic [3:0] DEF_PATTERN   = 4'b1011;
  localparam int         DEF_CNT_W     = 8;

endpackage : serial_pattern_detector_pkg

// File: rtl/serial_pattern_detector_if.sv
// Serial data in / match status out bundle for the pattern detector.
interface serial_pattern_detector_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);

  logic                 din;
  logic                 din_valid;
  logic                 clear_count;
  logic                 match;
  logic [CNT_W-1:0]     match_count;
  logic [PATTERN_W-1:0] history;
  logic                 busy;

  // Producer of the bit stream and consumer of the detector status.
  modport master (
    output din,
    output din_valid,
    output clear_count,
    input  match,
    input  match_count,
    input  history,
    input  busy
  );

  // The detector itself.
  modport slave (
    input  din,
    input  din_valid,
    input  clear_count,
    output match,
    output match_count,
    output history,
    output busy
  );

endinterface : serial_pattern_detector_if

// File: rtl/serial_pattern_detector_shift_reg.sv
// Enable-gated shift register; bit 0 receives the newest bit.
module serial_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] shift_q;
  logic [W-1:0] shift_d;

  // Each stage takes the value of its younger neighbour; stage 0 takes d_i.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign shift_d[gi] = d_i;
      end else begin : g_body
        assign shift_d[gi] = shift_q[gi-1];
      end
    end
  endgenerate

  // Shift one position per enabled cycle; hold otherwise.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else if (en_i) begin
      shift_q <= shift_d;
    end
  end

  assign q_o = shift_q;

endmodule : serial_shift_reg

// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector: registered match pulse, saturating match
// counter, history view and busy flag. Overlap behaviour fixed at elaboration.
module serial_pattern_detector
  import serial_pattern_detector_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = DEF_CNT_W
) (
  input  logic                     clock,
  input  logic                     Rst,
  serial_pattern_detector_if.slave bus
);

  // The fill counter runs 0..PATTERN_W and then saturates.
  localparam int                NF_W    = $clog2(PATTERN_W + 1);
  localparam logic [NF_W-1:0]   NF_FULL = NF_W'(PATTERN_W);
  localparam logic [NF_W-1:0]   NF_LAST = NF_W'(PATTERN_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_e               state_q;
  logic [NF_W-1:0]      nfill_q;
  logic                 match_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     count_q;
  logic [CNT_W-1:0]     count_d;
  logic [PATTERN_W-1:0] hist_q;
  logic [PATTERN_W-1:0] hist_d;
  logic                 window_full;
  logic                 hit;

  serial_shift_reg #(
    .W (PATTERN_W)
  ) u_hist (
    .clk_i  (clock),
    .rst_ni (Rst),
    .en_i   (bus.din_valid),
    .d_i    (bus.din),
    .q_o    (hist_q)
  );

  // History as it will look after this edge if the bit is accepted.
  assign hist_d = {hist_q[PATTERN_W-2:0], bus.din};

  // The incoming bit completes a full window of bits accepted since reset
  // (or since the last match in non-overlap mode); zeros left by reset never
  // count, so an all-zero pattern cannot fire early.
  assign window_full = (state_q == ST_RUN) || (nfill_q == NF_LAST);
  assign hit         = bus.din_valid && window_full && (hist_d == PATTERN);

  // Control FSM with registered match and busy outputs.
  always_ff @(posedge clock) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      nfill_q <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      match_q <= 1'b0;
      if (bus.din_valid) begin
        match_q <= hit;
        busy_q  <= 1'b1;
        if (hit && !OVERLAP) begin
          // The completing bit is consumed by this match; start a new window.
          state_q <= ST_FILL;
          nfill_q <= '0;
        end else begin
          if (nfill_q != NF_FULL) begin
            nfill_q <= nfill_q + 1'b1;
          end
          if (nfill_q >= NF_LAST) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_FILL;
          end
        end
      end
    end
  end

  // Next match count: the clear is applied before the increment, and the
  // increment stops at all-ones.
  always_comb begin
    count_d = bus.clear_count ? '0 : count_q;
    if (hit && (count_d != CNT_MAX)) begin
      count_d = count_d + 1'b1;
    end
  end

  // Match counter register.
  always_ff @(posedge clock) begin
    if (!Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = count_q;
  assign bus.history     = hist_q;
  assign bus.busy        = busy_q;

endmodule : serial_pattern_detector

// File: tb/tb_serial_pattern_detector.sv
// Scoreboard bench: four detector variants share one stimulus stream;
// a reference model pushes expected outputs, a monitor pops and compares.
module tb_serial_pattern_detector;

  localparam int NI = 4;

  logic clk;
  logic rst_n;
  logic din;
  logic din_valid;
  logic clear_count;

  // 0: default overlap, 1: non-overlap, 2: 2-bit counter, 3: pattern 0000
  serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if0 ();
  serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if1 ();
  serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(2)) if2 ();
  serial_pattern_detector_if #(.PATTERN_W(4), .CNT_W(8)) if3 ();

  assign if0.din = din;  assign if0.din_valid = din_valid;  assign if0.clear_count = clear_count;
  assign if1.din = din;  assign if1.din_valid = din_valid;  assign if1.clear_count = clear_count;
  assign if2.din = din;  assign if2.din_valid = din_valid;  assign if2.clear_count = clear_count;
  assign if3.din = din;  assign if3.din_valid = din_valid;  assign if3.clear_count = clear_count;

  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
    dut0 (.clock(clk), .Rst(rst_n), .bus(if0));
  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
    dut1 (.clock(clk), .Rst(rst_n), .bus(if1));
  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2))
    dut2 (.clock(clk), .Rst(rst_n), .bus(if2));
  serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CNT_W(8))
    dut3 (.clock(clk), .Rst(rst_n), .bus(if3));

  logic       act_m    [NI];
  logic [7:0] act_cnt  [NI];
  logic [3:0] act_hist [NI];
  logic       act_busy [NI];

  assign act_m[0] = if0.match;  assign act_cnt[0] = if0.match_count;
  assign act_m[1] = if1.match;  assign act_cnt[1] = if1.match_count;
  assign act_m[2] = if2.match;  assign act_cnt[2] = {6'b0, if2.match_count};
  assign act_m[3] = if3.match;  assign act_cnt[3] = if3.match_count;
  assign act_hist[0] = if0.history;  assign act_busy[0] = if0.busy;
  assign act_hist[1] = if1.history;  assign act_busy[1] = if1.busy;
  assign act_hist[2] = if2.history;  assign act_busy[2] = if2.busy;
  assign act_hist[3] = if3.history;  assign act_busy[3] = if3.busy;

  typedef struct packed {
    logic [NI-1:0]      m;
    logic [NI-1:0][7:0] cnt;
    logic [NI-1:0][3:0] hist;
    logic [NI-1:0]      busy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: history, bits accepted since the window last
  // restarted, busy, count, and the pending match pulse.
  logic [3:0] m_hist [NI];
  int         m_nbits[NI];
  bit         m_busy [NI];
  int         m_cnt  [NI];
  bit         m_match[NI];

  function automatic logic [3:0] pat_of(int i);
    return (i == 3) ? 4'b0000 : 4'b1011;
  endfunction

  function automatic bit ovl_of(int i);
    return (i != 1);
  endfunction

  function automatic int cmax_of(int i);
    return (i == 2) ? 3 : 255;
  endfunction

  // Advance the model by one clock edge with the given inputs and queue
  // the outputs every variant should show after that edge.
  function automatic void model_step(bit r, bit dv, bit d, bit clr);
    exp_t e;
    bit   fired;
    int   c;
    for (int i = 0; i < NI; i++) begin
      fired = 1'b0;
      if (!r) begin
        m_hist[i] = 4'b0; m_nbits[i] = 0; m_busy[i] = 1'b0; m_cnt[i] = 0; m_match[i] = 1'b0;
      end else begin
        if (dv) begin
          m_hist[i]  = {m_hist[i][2:0], d};
          m_nbits[i] = m_nbits[i] + 1;
          m_busy[i]  = 1'b1;
          fired      = (m_nbits[i] >= 4) && (m_hist[i] == pat_of(i));
          if (fired && !ovl_of(i)) m_nbits[i] = 0;
        end
        c = clr ? 0 : m_cnt[i];
        if (fired && c < cmax_of(i)) c = c + 1;
        m_cnt[i]   = c;
        m_match[i] = fired;
      end
      e.m[i]    = m_match[i];
      e.cnt[i]  = 8'(m_cnt[i]);
      e.hist[i] = m_hist[i];
      e.busy[i] = m_busy[i];
    end
    sb_q.push_back(e);
  endfunction

  task automatic chk(string name, int inst, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", name, inst, $time, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int i = 0; i < NI; i++) begin
        chk("match",   i, 8'(act_m[i]),    8'(e.m[i]));
        chk("count",   i, act_cnt[i],      e.cnt[i]);
        chk("history", i, 8'(act_hist[i]), 8'(e.hist[i]));
        chk("busy",    i, 8'(act_busy[i]), 8'(e.busy[i]));
      end
      if (e.m != '0)
        $display("txn t=%0t match_mask=%b counts=%0d/%0d/%0d/%0d", $time, e.m,
                 e.cnt[0], e.cnt[1], e.cnt[2], e.cnt[3]);
    end
  end

  // Drive one cycle of inputs, let the edge take them, then queue expectations.
  task automatic cycle(bit r, bit dv, bit d, bit clr);
    rst_n = r; din_valid = dv; din = d; clear_count = clr;
    @(posedge clk);
    model_step(r, dv, d, clr);
    #2;
  endtask

  task automatic bits(input logic [15:0] v, input int n, input bit clr_last);
    for (int k = n - 1; k >= 0; k--) cycle(1'b1, 1'b1, v[k], clr_last && (k == 0));
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; clear_count = 1'b0;
    #2;
    do_reset();
    // Single match on 1011
    bits(16'b1011, 4, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Overlapping vs non-overlapping on 1011011
    do_reset();
    bits(16'b1011011, 7, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Stall in the middle of the pattern
    do_reset();
    bits(16'b10, 2, 1'b0);
    repeat (5) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    bits(16'b11, 2, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Saturation of the 2-bit counter, then clear together with a match
    do_reset();
    repeat (5) bits(16'b1011, 4, 1'b0);
    bits(16'b011, 3, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    // Reset mid-stream discards the partial window
    do_reset();
    bits(16'b101, 3, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    bits(16'b1, 1, 1'b0);
    bits(16'b1011, 4, 1'b0);
    // All-zero pattern needs four real bits
    do_reset();
    bits(16'b000, 3, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    bits(16'b00, 2, 1'b0);
    // Randomised traffic with occasional clears and resets
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    w = 0;
    while (sb_q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_pattern_detector
